// File: rtl/adder_share_arbiter_pkg.sv
// Shared types and widths for the adder-sharing arbiter.
package adder_share_pkg;

    // Operand and sum widths of the shared ripple adder.
    localparam int OP_W  = 12;
    localparam int SUM_W = 13;

    // Top-level FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/adder11bit.sv
// 12-bit ripple-carry adder with carry-in 0 and a 13-bit sum.
// Purely combinational. The long carry chain is why the sum is sampled late.
module adder11bit
    import adder_share_pkg::*;
(
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    output logic [SUM_W-1:0] sum
);

    logic [OP_W:0]   carry;
    logic [OP_W-1:0] bit_sum;

    // Ripple the carry from bit 0 upward, one full adder per bit.
    // NOTE: every signal written in this block gets a default first, so no latch can be inferred.
    always_comb begin
        carry   = '0;
        bit_sum = '0;
        for (int i = 0; i < OP_W; i++) begin
            bit_sum[i]   = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign sum = {carry[OP_W], bit_sum};

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// It returns the first set request found by searching upward from ptr and
// wrapping at NUM_REQ. The grant is one-hot, or zero when nothing is requested.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               found
);

    logic [ID_W-1:0] cand;

    // Walk the candidates in priority order starting at ptr; the first hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = ID_W'((int'(ptr) + off) % NUM_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one ripple adder between NUM_REQ requesters.
// Requesters are served round-robin. The operand registers feed the adder and
// are held for SETTLE_CYCLES before the sum is registered and offered on the
// response handshake. Only one request is in flight at a time.
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter  int NUM_REQ       = 4,
    parameter  int SETTLE_CYCLES = 2,
    localparam int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*OP_W-1:0] req_a,
    input  logic [NUM_REQ*OP_W-1:0] req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [SUM_W-1:0]        rsp_sum,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    busy
);

    localparam int              CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_e           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [OP_W-1:0]  op_a_q,      op_a_d;
    logic [OP_W-1:0]  op_b_q,      op_b_d;
    logic [ID_W-1:0]  id_q,        id_d;
    logic [SUM_W-1:0] sum_q,       sum_d;
    logic [ID_W-1:0]  rr_ptr_q,    rr_ptr_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             busy_q,      busy_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_found;
    logic [SUM_W-1:0]   adder_sum;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .idx   (grant_idx),
        .found (grant_found)
    );

    // The adder sees only the held operand registers, never the live inputs.
    adder11bit u_adder (
        .a   (op_a_q),
        .b   (op_b_q),
        .sum (adder_sum)
    );

    // Accept is offered only while idle. It is also forced low while reset is
    // asserted, so that every output reads zero during reset.
    assign req_ready = (state_q == IDLE && rst_n) ? grant : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = sum_q;
    assign rsp_id    = id_q;
    assign busy      = busy_q;

    // Next-state logic: grant and latch operands, count the settle time, hold the response.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        id_d        = id_q;
        sum_d       = sum_q;
        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = rsp_valid_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    op_a_d  = req_a[grant_idx*OP_W +: OP_W];
                    op_b_d  = req_b[grant_idx*OP_W +: OP_W];
                    id_d    = grant_idx;
                    cnt_d   = CNT_LOAD;
                    state_d = SETTLE;
                    busy_d  = 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    sum_d       = adder_sum;
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rr_ptr_d    = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // All FSM state and datapath registers; reset aborts any in-flight request.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            id_q        <= '0;
            sum_q       <= '0;
            rr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            id_q        <= id_d;
            sum_q       <= sum_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter.
// A transaction-level model predicts req_ready, busy, rsp_valid, rsp_sum and
// rsp_id on every cycle. Directed scenarios pin the model with literal values,
// and a randomized phase stresses arbitration, backpressure and withdrawal.
module tb_adder_share_arbiter;
    import adder_share_pkg::*;

    localparam int NUM_REQ       = 4;
    localparam int SETTLE_CYCLES = 2;
    localparam int ID_W          = 2;
    localparam int LAT           = 1 + SETTLE_CYCLES;
    localparam int N_RAND_TX     = 3000;
    localparam int RAND_MAX_CYC  = 40000;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*OP_W-1:0] req_a;
    logic [NUM_REQ*OP_W-1:0] req_b;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [SUM_W-1:0]        rsp_sum;
    logic [ID_W-1:0]         rsp_id;
    logic                    busy;

    adder_share_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int cyc = 0;
    bit m_out = 1'b0;
    int m_acc, m_id, m_sum;
    int m_ptr = 0;
    int n_rsp = 0;
    int grants_to[NUM_REQ];
    int wait_g[NUM_REQ];
    int ck_g;
    bit ck_rv;
    logic [NUM_REQ-1:0] ck_ready;

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            int c;
            c = (ptr + k) % NUM_REQ;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic int oh_idx(input logic [NUM_REQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            grants_to[i] = 0;
            wait_g[i]    = 0;
        end
    end

    // Compare process: outputs are predicted from the model, then the model advances
    // over the handshakes that will happen at the coming rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_req_ready", req_ready, 0);
            check("reset_rsp_valid", rsp_valid, 0);
            check("reset_rsp_sum",   rsp_sum,   0);
            check("reset_rsp_id",    rsp_id,    0);
            check("reset_busy",      busy,      0);
            m_out = 1'b0;
            m_ptr = 0;
            for (int i = 0; i < NUM_REQ; i++) wait_g[i] = 0;
        end else begin
            cyc++;
            ck_rv    = m_out && (cyc >= m_acc + LAT);
            ck_g     = m_out ? -1 : rr_pick(req_valid, m_ptr);
            ck_ready = (ck_g >= 0) ? NUM_REQ'(1 << ck_g) : '0;
            check("model_busy",      busy,      m_out);
            check("model_rsp_valid", rsp_valid, ck_rv);
            check("model_req_ready", req_ready, ck_ready);
            if (ck_rv) begin
                check("model_rsp_sum", rsp_sum, m_sum);
                check("model_rsp_id",  rsp_id,  m_id);
            end
            for (int i = 0; i < NUM_REQ; i++) if (!req_valid[i]) wait_g[i] = 0;
            if (ck_g >= 0) begin
                check("starvation", (wait_g[ck_g] < NUM_REQ), 1);
                for (int i = 0; i < NUM_REQ; i++) if (i != ck_g && req_valid[i]) wait_g[i]++;
                wait_g[ck_g] = 0;
                grants_to[ck_g]++;
                m_out = 1'b1;
                m_acc = cyc;
                m_id  = ck_g;
                m_sum = int'(req_a[OP_W*ck_g +: OP_W]) + int'(req_b[OP_W*ck_g +: OP_W]);
            end else if (ck_rv && rsp_ready) begin
                m_out = 1'b0;
                m_ptr = (m_id + 1) % NUM_REQ;
                n_rsp++;
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[OP_W*i +: OP_W] = OP_W'(a);
        req_b[OP_W*i +: OP_W] = OP_W'(b);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    // Waits for a grant; on return the accepting edge has passed.
    task automatic wait_grant(output int g);
        g = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                g = oh_idx(req_ready);
                break;
            end
        end
        if (g < 0) check("grant_timeout", 0, 1);
        else tick();
    endtask

    // Waits for rsp_valid; waited counts the sampled cycles up to and including the first valid one.
    task automatic wait_rsp(output logic [SUM_W-1:0] s, output logic [ID_W-1:0] id, output int waited);
        bit found;
        found  = 1'b0;
        waited = 0;
        s      = '0;
        id     = '0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            waited++;
            if (rsp_valid) begin
                s     = rsp_sum;
                id    = rsp_id;
                found = 1'b1;
                break;
            end
        end
        if (!found) check("rsp_timeout", 0, 1);
        else tick();
    endtask

    // ---------------- stimulus ----------------
    int g, w, g2_before, start_rsp, rcyc;
    logic [SUM_W-1:0]   s;
    logic [ID_W-1:0]    id;
    logic [NUM_REQ-1:0] granted;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int exp_sums[5]  = '{1, 111, 221, 331, 1};
    bit seen;

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        // 1: single request at the operand maximum.
        rsp_ready = 1'b1;
        set_op(0, 4095, 4095);
        req_valid = 4'b0001;
        wait_grant(g);
        req_valid = '0;
        check("t1_grant", g, 0);
        wait_rsp(s, id, w);
        check("t1_sum", s, 8190);
        check("t1_id", id, 0);
        check("t1_latency", w, LAT);

        // 2: all requesters continuously valid after reset.
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) set_op(i, i * 100 + 1, i * 10);
        req_valid = '1;
        for (int n = 0; n < 5; n++) begin
            wait_grant(g);
            check("t2_order", g, exp_order[n]);
            wait_rsp(s, id, w);
            check("t2_sum", s, exp_sums[n]);
            check("t2_id", id, exp_order[n]);
        end
        req_valid = '0;
        tick();

        // 3: backpressure held for 10 cycles while another request waits.
        rsp_ready = 1'b0;
        set_op(1, 7, 9);
        req_valid = 4'b0010;
        wait_grant(g);
        check("t3_grant", g, 1);
        set_op(0, 5, 6);
        req_valid = 4'b0001;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("t3_rsp_seen", seen, 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t3_hold_valid", rsp_valid, 1);
            check("t3_hold_sum",   rsp_sum,   16);
            check("t3_hold_id",    rsp_id,    1);
            check("t3_hold_ready", req_ready, 0);
        end
        tick();
        rsp_ready = 1'b1;
        tick();
        @(negedge clk);
        check("t3_idle_busy",  busy,      0);
        check("t3_idle_valid", rsp_valid, 0);
        check("t3_idle_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        wait_rsp(s, id, w);
        check("t3_next_sum", s, 11);
        check("t3_next_id",  id, 0);

        // 4: requester 2 withdraws while the arbiter is busy.
        g2_before = grants_to[2];
        set_op(3, 2000, 48);
        req_valid = 4'b1000;
        wait_grant(g);
        check("t4_grant", g, 3);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        wait_rsp(s, id, w);
        check("t4_sum", s, 2048);
        check("t4_id",  id, 3);
        repeat (10) tick();
        check("t4_withdraw", grants_to[2], g2_before);

        // 5: reset in the middle of SETTLE.
        set_op(1, 1, 1);
        req_valid = 4'b0010;
        wait_grant(g);
        req_valid = '0;
        wait_rsp(s, id, w);
        set_op(1, 100, 23);
        req_valid = 4'b0010;
        wait_grant(g);
        check("t5_grant", g, 1);
        req_valid = '1;
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_rst_valid", rsp_valid, 0);
        check("t5_rst_busy",  busy,      0);
        check("t5_rst_ready", req_ready, 0);
        check("t5_rst_sum",   rsp_sum,   0);
        check("t5_rst_id",    rsp_id,    0);
        tick();
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t5_no_rsp", rsp_valid, 0);
        end
        tick();
        req_valid = '1;
        wait_grant(g);
        check("t5_ptr_zero", g, 0);
        req_valid = '0;
        wait_rsp(s, id, w);
        check("t5_after_id", id, 0);

        // 6: randomized traffic, withdrawal and backpressure.
        start_rsp = n_rsp;
        rcyc      = 0;
        while ((n_rsp - start_rsp) < N_RAND_TX && rcyc < RAND_MAX_CYC) begin
            @(negedge clk);
            granted = req_ready & req_valid;
            tick();
            rcyc++;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && !granted[i]) begin
                    if ($urandom_range(0, 31) == 0) req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    if ($urandom_range(0, 7) == 0) set_op(i, 4095, int'($urandom_range(0, 4095)));
                    else set_op(i, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
                end
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
        end
        check("t6_completed", ((n_rsp - start_rsp) >= N_RAND_TX), 1);

        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (20) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
